serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/b1_adder.sv | 13 +
 rtl/serial_addsub.sv | 102 ++++++++++
 tb/tb_serial_addsub.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encodings
// and the bit-counter width rule. Imported by the RTL and the testbench.
package serial_addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One spare bit over the index width keeps the counter well-defined for every WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/b1_adder.sv
// 1-bit full adder shared by the serial datapath.
module b1_adder (
    input  logic X,
    input  logic Y,
    input  logic C_in,
    output logic Z,
    output logic C_out
);

    assign Z     = X ^ Y ^ C_in;
    assign C_out = (X & Y) | (C_in & (X ^ Y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full adder walks the operands LSB first,
// taking WIDTH cycles per operation plus one IDLE and one DONE cycle.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             c_out_reg;
    logic             overflow_reg;
    logic             sum_bit;
    logic             carry_bit;

    // Operands are shifted right each RUN cycle so the adder always sees bit 0.
    b1_adder u_b1_adder (
        .X     (a_reg[0]),
        .Y     (b_reg[0]),
        .C_in  (carry_reg),
        .Z     (sum_bit),
        .C_out (carry_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with mode.
                        a_reg     <= a;
                        b_reg     <= mode ? ~b : b;
                        carry_reg <= mode;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= carry_bit;
                    if (cnt_reg == LAST_BIT) begin
                        c_out_reg    <= carry_bit;
                        overflow_reg <= carry_reg ^ carry_bit;
                        state_reg    <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_result_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    result_reg[gi] <= 1'b0;
                end else if (state_reg == ST_RUN && cnt_reg == CW'(gi)) begin
                    result_reg[gi] <= sum_bit;
                end
            end
        end
    endgenerate

    assign ready    = (state_reg == ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign result   = result_reg;
    assign c_out    = c_out_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back ops.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_result;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait for IDLE, pulse start for one cycle, return cycles until done is seen.
    task automatic do_op(input logic m, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        mode  = m;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int t_done[3];
        int guard;
        logic [WIDTH-1:0] seen_result;

        vecs[0] = '{1'b0, 8'd5,   8'd3,   8'd8,   1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'd5,   8'd3,   8'd2,   1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'd3,   8'd5,   8'd254, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'd128, 8'd1,   8'd127, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'd127, 8'd255, 8'd128, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset_ready",    int'(ready),    1);
        check("reset_done",     int'(done),     0);
        check("reset_result",   int'(result),   0);
        check("reset_cout",     int'(c_out),    0);
        check("reset_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
            $display("op %0d: mode=%0d a=%0d b=%0d -> result=%0d c_out=%0d ovf=%0d lat=%0d",
                     i, vecs[i].mode, vecs[i].a, vecs[i].b, result, c_out, overflow, lat);
            check($sformatf("vec%0d_latency", i),  lat,             9);
            check($sformatf("vec%0d_result", i),   int'(result),    int'(vecs[i].exp_result));
            check($sformatf("vec%0d_cout", i),     int'(c_out),     int'(vecs[i].exp_cout));
            check($sformatf("vec%0d_overflow", i), int'(overflow),  int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_ready_in_done", i), int'(ready), 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_width", i), int'(done),  0);
            check($sformatf("vec%0d_ready_after", i), int'(ready), 1);
            check($sformatf("vec%0d_hold_result", i), int'(result), int'(vecs[i].exp_result));
        end

        // Second start 3 cycles into RUN must be ignored.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'd5; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("ign_state_run", int'(dut.state_reg), int'(ST_RUN));
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'd100; b = 8'd50;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        seen_result = '0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                n_done++;
                seen_result = result;
            end
            @(negedge clk);
        end
        $display("ignored-start: done pulses=%0d result=%0d", n_done, seen_result);
        check("ign_done_count", n_done, 1);
        check("ign_result", int'(seen_result), 8);
        check("ign_result_hold", int'(result), 8);

        // Reset asserted at RUN cycle 4 aborts with no done pulse.
        start = 1'b1; mode = 1'b0; a = 8'd200; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready",    int'(ready),    1);
        check("abort_done",     int'(done),     0);
        check("abort_result",   int'(result),   0);
        check("abort_cout",     int'(c_out),    0);
        check("abort_overflow", int'(overflow), 0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        do_op(1'b0, 8'd1, 8'd1, lat);
        $display("post-reset op: 1+1 -> result=%0d lat=%0d", result, lat);
        check("post_reset_latency", lat, 9);
        check("post_reset_result", int'(result), 2);
        check("post_reset_cout", int'(c_out), 0);
        check("post_reset_overflow", int'(overflow), 0);

        // start held high: three operations, done spaced WIDTH+2 cycles.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 8'd10; b = 8'd20;
        n_done = 0;
        guard = 0;
        while (n_done < 3 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (done) begin
                t_done[n_done] = cyc;
                $display("held-start op %0d: done at cycle %0d result=%0d", n_done, cyc, result);
                check($sformatf("held_result%0d", n_done), int'(result), 30);
                n_done++;
            end
        end
        start = 1'b0;
        check("held_done_count", n_done, 3);
        if (n_done == 3) begin
            check("held_spacing_1", t_done[1] - t_done[0], 10);
            check("held_spacing_2", t_done[2] - t_done[1], 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
